// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: first-word-fall-through FIFO controller for an external registered-read dual-port RAM
module fifo_sync_ctrl #(
    parameter int ADDR_BITS       = 8,
    parameter int WORD_LENGTH     = 8,
    parameter int ALMOST_FULL_TH  = 2**ADDR_BITS-1,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [WORD_LENGTH-1:0] i_wr_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [WORD_LENGTH-1:0] o_rd_data,
    output logic                   o_ram_we,
    output logic [ADDR_BITS-1:0]   o_ram_waddr,
    output logic [WORD_LENGTH-1:0] o_ram_wdata,
    output logic [ADDR_BITS-1:0]   o_ram_raddr,
    input  logic [WORD_LENGTH-1:0] i_ram_rdata,
    output logic [ADDR_BITS:0]     o_count,
    output logic                   o_almost_full,
    output logic                   o_almost_empty
);
    localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS:0]   AF_TH   = ALMOST_FULL_TH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   AE_TH   = ALMOST_EMPTY_TH[ADDR_BITS:0];
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0]   count, count_after_pop;
    logic                 rd_valid_q, push, pop;

    assign o_wr_ready      = i_rst_n & (count != DEPTH);
    assign push            = i_wr_valid & o_wr_ready;
    assign pop             = rd_valid_q & i_rd_ready;
    assign count_after_pop = count - (pop ? CNT_ONE : '0);

    assign o_ram_we       = push;
    assign o_ram_waddr    = wr_ptr;
    assign o_ram_wdata    = i_wr_data;
    // look ahead to the next slot on a pop so back-to-back reads have no bubble
    assign o_ram_raddr    = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = i_ram_rdata;
    assign o_count        = count;
    assign o_almost_full  = count >= AF_TH;
    assign o_almost_empty = count <= AE_TH;

    // pointers advance on each accepted write / consumed read, wrapping modulo depth
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // occupancy and read-valid; count only covers entries already written, so the
    // RAM output sampled at this edge is never stale
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count      <= count_after_pop + (push ? CNT_ONE : '0);
            rd_valid_q <= count_after_pop != '0;
        end
    end
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: random + directed scoreboard bench with a behavioural RAM and queue model
module tb_fifo_sync_ctrl;
    localparam int AB = 2;
    localparam int WL = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, rd_ready;
    logic [WL-1:0] wr_data;
    logic          wr_ready, rd_valid, ram_we, almost_full, almost_empty;
    logic [WL-1:0] rd_data, ram_wdata, ram_rdata;
    logic [AB-1:0] ram_waddr, ram_raddr;
    logic [AB:0]   count;

    fifo_sync_ctrl #(.ADDR_BITS(AB), .WORD_LENGTH(WL)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
        .o_ram_we(ram_we), .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
        .o_ram_raddr(ram_raddr), .i_ram_rdata(ram_rdata),
        .o_count(count), .o_almost_full(almost_full), .o_almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    // dual-port RAM: registered read, read-before-write, contents survive reset
    logic [WL-1:0] mem [DEPTH];
    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: each entry remembers the cycle it was accepted; the head becomes
    // visible two cycles after its write
    typedef struct { logic [WL-1:0] d; int c; } ent_t;
    ent_t q[$];
    int   cyc = 0;
    logic exp_valid, exp_full;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_count", int'(count), 0);
            chk("rst_rd_valid", int'(rd_valid), 0);
            chk("rst_wr_ready", int'(wr_ready), 0);
            chk("rst_ram_we", int'(ram_we), 0);
            chk("rst_almost_empty", int'(almost_empty), 1);
            chk("rst_almost_full", int'(almost_full), 0);
        end else begin
            cyc++;
            exp_full  = q.size() == DEPTH;
            exp_valid = q.size() > 0 && q[0].c <= cyc - 2;
            chk("count", int'(count), q.size());
            chk("wr_ready", int'(wr_ready), int'(!exp_full));
            chk("ram_we", int'(ram_we), int'(wr_valid && !exp_full));
            chk("almost_full", int'(almost_full), int'(q.size() >= DEPTH - 1));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= 1));
            chk("rd_valid", int'(rd_valid), int'(exp_valid));
            if (exp_valid) chk("rd_data", int'(rd_data), int'(q[0].d));
            if (exp_valid && rd_ready) void'(q.pop_front());
            if (wr_valid && !exp_full) q.push_back('{wr_data, cyc});
        end
    end

    task automatic step(input logic wv, input logic [WL-1:0] wd, input logic rr);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // single entry fall-through
        step(1, 8'hA1, 0);
        repeat (3) step(0, 8'h00, 0);
        repeat (2) step(0, 8'h00, 1);
        // fill to full, attempt a fifth write, then drain without bubbles
        for (int i = 0; i < 4; i++) step(1, 8'h10 + 8'(i), 0);
        step(1, 8'h14, 0);
        step(0, 8'h00, 0);
        repeat (6) step(0, 8'h00, 1);
        // streaming across pointer wrap
        for (int i = 0; i < 20; i++) step(1, 8'h20 + 8'(i), 1);
        repeat (4) step(0, 8'h00, 1);
        // count=1 with simultaneous push and pop
        step(1, 8'h54, 0);
        repeat (2) step(0, 8'h00, 0);
        step(1, 8'h55, 1);
        repeat (4) step(0, 8'h00, 1);
        // reset mid-stream with three entries stored
        for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0);
        step(0, 8'h00, 0);
        rst_n = 1'b0;
        repeat (2) step(1, 8'h66, 1);
        rst_n = 1'b1;
        step(1, 8'h77, 0);
        repeat (2) step(0, 8'h00, 0);
        repeat (2) step(0, 8'h00, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 3) != 0), 8'($urandom), logic'($urandom_range(0, 2) != 0));
        repeat (8) step(0, 8'h00, 1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
